// File: rtl/mmp_cmd_receiver_pkg.sv
// Shared definitions for the MMP command path: opcode table, word field offsets, FSM states.
// MMP_control imports the same package, so both ends decode from one opcode table.
package mmp_cmd_receiver_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [4:0] MMP_OP_VSYNC      = 5'b00010;
  localparam logic [4:0] MMP_OP_PSG        = 5'b10001;
  localparam logic [4:0] MMP_OP_OPLL       = 5'b10010;
  localparam logic [4:0] MMP_OP_SCC        = 5'b10011;
  localparam logic [4:0] MMP_OP_MOVOL      = 5'b11000;
  localparam logic [4:0] MMP_OP_ROVOL      = 5'b11001;
  localparam logic [4:0] MMP_OP_SCC_MODULE = 5'b11010;

  // 24-bit word layout: {op[23:19], sub[18:16], addr[15:8], data[7:0]}
  localparam int MMP_OP_LSB   = 19;
  localparam int MMP_SUB_LSB  = 16;
  localparam int MMP_ADDR_LSB = 8;
  localparam int MMP_DATA_LSB = 0;

  typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_PUSH} rx_state_t;

  function automatic logic mmp_op_valid(input logic [4:0] op);
    case (op)
      MMP_OP_VSYNC, MMP_OP_PSG, MMP_OP_OPLL, MMP_OP_SCC,
      MMP_OP_MOVOL, MMP_OP_ROVOL, MMP_OP_SCC_MODULE: mmp_op_valid = HIGH;
      default:                                       mmp_op_valid = LOW;
    endcase
  endfunction

endpackage

// File: rtl/mmp_cmd_receiver_sync_edge.sv
// Synchronizer for the async Pico byte strobe, followed by a rising-edge detector.
module mmp_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_CLK,
  input  logic i_RST_n,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/mmp_cmd_receiver.sv
// Assembles 3 strobed bytes (MSB first) into a 24-bit MMP command and writes it to the command FIFO.
module mmp_cmd_receiver
  import mmp_cmd_receiver_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [19:0] BYTE_TIMEOUT = 20'd17857
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic [7:0]  i_RX_DATA,
  input  logic        i_RX_STB,
  output logic        o_RX_READY,
  output logic        o_fifo_push_s,
  output logic [23:0] o_fifo_push_dt,
  input  logic        i_fifo_FULL,
  input  logic        i_STAT_CLR,
  output logic        o_OVF,
  output logic [7:0]  o_DROP_CNT
);

  rx_state_t   state, state_n;
  logic [19:0] timer, timer_n;
  logic [23:0] word, word_n;
  logic        rdy_n, ovf_n, drop, push;
  logic [7:0]  cnt_n;
  logic        rx_ev;

  mmp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .i_async (i_RX_STB),
    .o_rise  (rx_ev)
  );

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state      <= ST_B0;
      timer      <= '0;
      word       <= '0;
      o_RX_READY <= HIGH;
      o_OVF      <= LOW;
      o_DROP_CNT <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      word       <= word_n;
      o_RX_READY <= rdy_n;
      o_OVF      <= ovf_n;
      o_DROP_CNT <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    word_n  = word;
    drop    = LOW;
    push    = LOW;
    ovf_n   = o_OVF;
    case (state)
      ST_B0: begin
        timer_n = '0;
        if (rx_ev) begin
          if (mmp_op_valid(i_RX_DATA[7:3])) begin
            word_n[23:16] = i_RX_DATA;
            state_n       = ST_B1;
          end else begin
            drop = HIGH;
          end
        end
      end
      // An arriving byte beats the timeout on the expiry cycle.
      ST_B1, ST_B2: begin
        if (rx_ev) begin
          timer_n = '0;
          if (state == ST_B1) begin
            word_n[15:8] = i_RX_DATA;
            state_n      = ST_B2;
          end else begin
            word_n[7:0] = i_RX_DATA;
            state_n     = ST_PUSH;
          end
        end else if (timer == BYTE_TIMEOUT - 20'd1) begin
          drop    = HIGH;
          timer_n = '0;
          state_n = ST_B0;
        end else begin
          timer_n = timer + 20'd1;
        end
      end
      ST_PUSH: begin
        timer_n = '0;
        if (!i_fifo_FULL) begin
          push    = HIGH;
          state_n = ST_B0;
        end
        if (rx_ev) begin
          drop  = HIGH;
          ovf_n = HIGH;
        end
      end
      default: state_n = ST_B0;
    endcase

    rdy_n = !(state == ST_PUSH && i_fifo_FULL);

    cnt_n = o_DROP_CNT;
    if (i_STAT_CLR) begin
      ovf_n = LOW;
      cnt_n = '0;
    end else if (drop && o_DROP_CNT != 8'hFF) begin
      cnt_n = o_DROP_CNT + 8'd1;
    end
  end

  // Push is gated directly by FULL so a write can never land on a full FIFO.
  assign o_fifo_push_s  = push;
  assign o_fifo_push_dt = word;

endmodule

// File: tb/tb_mmp_cmd_receiver.sv
// Randomized + directed bench for mmp_cmd_receiver with a byte-level reference model.
module tb_mmp_cmd_receiver;

  localparam int SYNC = 2;
  localparam int TO   = 17857;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_stb = 1'b0;
  logic        rx_ready;
  logic        push_s;
  logic [23:0] push_dt;
  logic        full = 1'b0;
  logic        stat_clr = 1'b0;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  logic [23:0] got[$];

  mmp_cmd_receiver #(.SYNC_STAGES(SYNC), .BYTE_TIMEOUT(20'd17857)) dut (
    .i_CLK          (clk),
    .i_RST_n        (rst_n),
    .i_RX_DATA      (rx_data),
    .i_RX_STB       (rx_stb),
    .o_RX_READY     (rx_ready),
    .o_fifo_push_s  (push_s),
    .o_fifo_push_dt (push_dt),
    .i_fifo_FULL    (full),
    .i_STAT_CLR     (stat_clr),
    .o_OVF          (ovf),
    .o_DROP_CNT     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit op_ok(input logic [7:0] b);
    return b[7:3] inside {5'b00010, 5'b10001, 5'b10010, 5'b10011, 5'b11000, 5'b11001, 5'b11010};
  endfunction

  // Reference model: strobe rises become byte events SYNC edges later; bytes are collected into a word.
  int          m_cyc = 0;
  bit          m_prev = 0;
  int          ev_q[$];
  int          m_n = 0;
  logic [23:0] m_word = '0;
  int          m_timer = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;
  bit          m_rdy = 1;

  always @(posedge clk) begin
    bit ev, drop;
    m_cyc++;
    if (!rst_n) begin
      ev_q.delete();
      m_prev = 0; m_n = 0; m_word = '0; m_timer = 0;
      m_ovf = 0; m_cnt = 0; m_rdy = 1;
    end else begin
      ev = 0;
      drop = 0;
      if (ev_q.size() > 0 && ev_q[0] == m_cyc) begin
        ev = 1;
        void'(ev_q.pop_front());
      end
      if (rx_stb && !m_prev) ev_q.push_back(m_cyc + SYNC);
      m_prev = rx_stb;
      m_rdy = !(m_n == 3 && full);
      if (m_n == 3) begin
        if (!full) m_n = 0;
        if (ev) begin drop = 1; m_ovf = 1; end
      end else if (ev) begin
        if (m_n == 0 && !op_ok(rx_data)) drop = 1;
        else begin
          m_word[23 - 8*m_n -: 8] = rx_data;
          m_n++;
          m_timer = 0;
        end
      end else if (m_n > 0) begin
        if (m_timer == TO - 1) begin drop = 1; m_n = 0; m_timer = 0; end
        else m_timer++;
      end
      if (stat_clr) begin m_ovf = 0; m_cnt = 0; end
      else if (drop && m_cnt < 255) m_cnt++;
    end
  end

  always @(negedge clk) begin
    bit exp_push;
    if (chk_en) begin
      exp_push = (m_n == 3) && !full;
      chk("push_s", push_s, exp_push);
      if (exp_push) chk("push_dt", push_dt, m_word);
      chk("rx_ready", rx_ready, m_rdy);
      chk("ovf", ovf, m_ovf);
      chk("drop_cnt", drop_cnt, m_cnt);
      if (push_s) got.push_back(push_dt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe held high 4 cycles; optional STAT_CLR aligned with the byte's event cycle.
  task automatic send(input logic [7:0] b, input int gap, input bit clr_on_ev = 0);
    rx_data = b;
    rx_stb  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (clr_on_ev && i == 2) stat_clr = 1'b1;
      if (i == 3) stat_clr = 1'b0;
    end
    rx_stb = 1'b0;
    tick(gap);
  endtask

  task automatic clr_pulse();
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[7];
    ops = '{8'h10, 8'h88, 8'h90, 8'h98, 8'hC0, 8'hC8, 8'hD0};
    tick(1);
    chk_en = 1;
    tick(2);
    chk("rst_ready", rx_ready, 1);
    chk("rst_push", push_s, 0);
    chk("rst_dt", push_dt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: plain PSG word
    got.delete();
    send(8'h8A, 46); send(8'h03, 46); send(8'h5C, 46);
    chk("t1_n", got.size(), 1);
    if (got.size() > 0) chk("t1_w", got[0], 24'h8A035C);
    chk("t1_cnt", drop_cnt, 0);

    // 2: invalid opcode dropped
    got.delete();
    send(8'hF8, 6); send(8'h90, 6); send(8'h07, 6); send(8'h21, 6);
    chk("t2_n", got.size(), 1);
    if (got.size() > 0) chk("t2_w", got[0], 24'h900721);
    chk("t2_cnt", drop_cnt, 1);

    // 3: inter-byte timeout
    clr_pulse(); got.delete();
    send(8'h98, 4); send(8'h12, TO + 5);
    send(8'h10, 4); send(8'h00, 4); send(8'h00, 6);
    chk("t3_n", got.size(), 1);
    if (got.size() > 0) chk("t3_w", got[0], 24'h100000);
    chk("t3_cnt", drop_cnt, 1);

    // 4: FIFO full stall and overflow
    clr_pulse(); got.delete();
    full = 1'b1;
    send(8'h8A, 4); send(8'h07, 4); send(8'h38, 6);
    chk("t4_ready", rx_ready, 0);
    chk("t4_nopush", got.size(), 0);
    send(8'h55, 4);
    chk("t4_ovf", ovf, 1);
    chk("t4_cnt", drop_cnt, 1);
    full = 1'b0;
    tick(2);
    chk("t4_n", got.size(), 1);
    if (got.size() > 0) chk("t4_w", got[0], 24'h8A0738);
    chk("t4_ready_back", rx_ready, 1);

    // 5: reset mid-word
    got.delete();
    send(8'h92, 4); send(8'h10, 3);
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    send(8'hC0, 4); send(8'h00, 4); send(8'h04, 6);
    chk("t5_n", got.size(), 1);
    if (got.size() > 0) chk("t5_w", got[0], 24'hC00004);
    chk("t5_ovf", ovf, 0);

    // byte landing exactly on the expiry cycle wins; one cycle later it loses
    got.delete();
    send(8'h98, TO - 4); send(8'h12, 4); send(8'h34, 6);
    send(8'h98, TO - 3); send(8'h00, 6);
    chk("tb_n", got.size(), 1);
    if (got.size() > 0) chk("tb_w", got[0], 24'h981234);
    chk("tb_cnt", drop_cnt, 2);

    // clear on the same cycle as a drop
    send(8'hF8, 4, 1);
    chk("clr_vs_drop", drop_cnt, 0);

    // 6: saturation then clear
    for (int i = 0; i < 300; i++) send(8'hF8, 2);
    chk("t6_sat", drop_cnt, 8'hFF);
    clr_pulse();
    chk("t6_cnt", drop_cnt, 0);
    chk("t6_ovf", ovf, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      if ($urandom_range(1, 0) == 1) b = ops[$urandom_range(6, 0)] | 8'($urandom_range(7, 0));
      else b = 8'($urandom);
      if ($urandom_range(9, 0) < 3) full = ~full;
      if ($urandom_range(19, 0) == 0) stat_clr = 1'b1;
      send(b, $urandom_range(8, 0));
      stat_clr = 1'b0;
    end
    full = 1'b0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
